// File: rtl/dnn_pkg.sv
// Shared types and constants for the dnn_core_seq lane sequencer.
package dnn_pkg;

    localparam int F_SIZE_DEF = 512;
    localparam int NORM_LAT   = 1;
    localparam int DRAIN_CYC  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_NORM,
        S_CAPT,
        S_OUT
    } seq_state_t;

endpackage

// File: rtl/dnn_seq_ctr.sv
// Job counter: latches the clamped job length and tracks the current input index.
module dnn_seq_ctr
    import dnn_pkg::*;
#(
    parameter int F_SIZE = F_SIZE_DEF,
    parameter int AW     = $clog2(F_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW:0]   len,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] pf_addr,
    output logic          last,
    output logic          pf_valid
);

    localparam logic [AW:0] F_MAX = (AW+1)'(F_SIZE);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    // One bit wider than an address so a full-depth job never wraps.
    logic [AW:0] cnt;
    logic [AW:0] len_q;
    logic [AW:0] cnt_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (load) begin
            cnt   <= '0;
            len_q <= (len > F_MAX) ? F_MAX : len;
        end else if (inc) begin
            cnt   <= cnt_nxt;
        end
    end

    assign cnt_nxt  = cnt + ONE;
    assign addr     = cnt[AW-1:0];
    assign pf_addr  = cnt_nxt[AW-1:0];
    assign last     = (cnt == len_q - ONE);
    assign pf_valid = (cnt_nxt < len_q);

endmodule

// File: rtl/dnn_core_seq.sv
// Sequencer for one tiny_dnn_core lane and its normalize stage; returns one fp32 dot product per job.
module dnn_core_seq
    import dnn_pkg::*;
#(
    parameter int F_SIZE = F_SIZE_DEF,
    parameter int AW     = $clog2(F_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [15:0]   w_data,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          x_re,
    output logic [AW-1:0] x_addr,
    input  logic [15:0]   x_rdata,
    output logic          core_write,
    output logic          core_exec,
    output logic          core_init,
    output logic [AW-1:0] core_a,
    output logic [15:0]   core_d,
    output logic          norm_en,
    input  logic [31:0]   nrm,
    output logic          busy,
    output logic [31:0]   result,
    output logic          result_valid,
    input  logic          result_ready
);

    seq_state_t    state;
    logic          load;
    logic [AW-1:0] cnt_addr;
    logic [AW-1:0] pf_addr;
    logic          last;
    logic          pf_valid;

    assign load = (state == S_IDLE) && start && (len != '0);

    dnn_seq_ctr #(.F_SIZE(F_SIZE), .AW(AW)) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .len      (len),
        .inc      (state == S_RUN),
        .addr     (cnt_addr),
        .pf_addr  (pf_addr),
        .last     (last),
        .pf_valid (pf_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state <= S_INIT;
                        end else begin
                            // Empty job: no core traffic, answer zero straight away.
                            result       <= '0;
                            result_valid <= 1'b1;
                            state        <= S_OUT;
                        end
                    end
                end
                S_INIT:  state <= S_RUN;
                S_RUN:   if (last) state <= S_DRAIN;
                S_DRAIN: state <= S_NORM;
                S_NORM:  state <= S_CAPT;
                S_CAPT: begin
                    result       <= nrm;
                    result_valid <= 1'b1;
                    state        <= S_OUT;
                end
                S_OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        core_write = 1'b0;
        core_exec  = 1'b0;
        core_init  = 1'b0;
        core_a     = '0;
        core_d     = '0;
        x_re       = 1'b0;
        x_addr     = '0;
        norm_en    = 1'b0;
        case (state)
            S_IDLE: begin
                core_write = w_we;
                core_a     = w_addr;
                core_d     = w_data;
            end
            S_INIT: begin
                core_init = 1'b1;
                x_re      = 1'b1;
            end
            S_RUN: begin
                core_exec = 1'b1;
                core_a    = cnt_addr;
                core_d    = x_rdata;
                x_re      = pf_valid;
                x_addr    = pf_valid ? pf_addr : '0;
            end
            S_NORM:  norm_en = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_dnn_core_seq.sv
// Bench for dnn_core_seq: models the input buffer, core lane and normalize, checks results against dot products.
module tb_dnn_core_seq;

    localparam int F_SIZE = 512;
    localparam int AW     = 9;

    logic          clk;
    logic          rst_n;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_data;
    logic          start;
    logic [AW:0]   len_in;
    logic          x_re;
    logic [AW-1:0] x_addr;
    logic [15:0]   x_rdata;
    logic          core_write;
    logic          core_exec;
    logic          core_init;
    logic [AW-1:0] core_a;
    logic [15:0]   core_d;
    logic          norm_en;
    logic [31:0]   nrm;
    logic          busy;
    logic [31:0]   result;
    logic          result_valid;
    logic          result_ready;

    dnn_core_seq #(.F_SIZE(F_SIZE), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_we         (w_we),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .start        (start),
        .len          (len_in),
        .x_re         (x_re),
        .x_addr       (x_addr),
        .x_rdata      (x_rdata),
        .core_write   (core_write),
        .core_exec    (core_exec),
        .core_init    (core_init),
        .core_a       (core_a),
        .core_d       (core_d),
        .norm_en      (norm_en),
        .nrm          (nrm),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] real_to_fp32(input real v);
        real         a;
        int          e;
        logic        s;
        logic [31:0] man;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        man = 32'($rtoi((a - 1.0) * 8388608.0));
        return {s, e[7:0], man[22:0]};
    endfunction

    function automatic real bf16_to_real(input logic [15:0] b);
        int  e;
        real m;
        e = int'(b[14:7]);
        if (e == 0) return 0.0;
        m = 1.0 + real'(b[6:0]) / 128.0;
        while (e > 127) begin m = m * 2.0; e--; end
        while (e < 127) begin m = m / 2.0; e++; end
        return b[15] ? -m : m;
    endfunction

    function automatic logic [15:0] int_to_bf16(input int k);
        logic [31:0] f;
        f = real_to_fp32(real'(k));
        return f[31:16];
    endfunction

    // Environment: synchronous input buffer, core lane (one-cycle product register) and normalize.
    logic [15:0] x_mem  [F_SIZE];
    logic [15:0] w_core [F_SIZE];
    real         acc;
    real         pend;
    logic [31:0] exec_total;
    logic [31:0] init_total;
    logic [AW-1:0] a_log [4096];

    initial begin
        acc        = 0.0;
        pend       = 0.0;
        exec_total = '0;
        init_total = '0;
        nrm        = 32'hDEAD_BEEF;
        x_rdata    = '0;
    end

    always @(posedge clk) begin
        if (x_re) x_rdata <= x_mem[x_addr];
        if (core_write) w_core[core_a] <= core_d;
        if (core_init) begin
            acc        <= 0.0;
            pend       <= 0.0;
            init_total <= init_total + 1;
        end else begin
            acc  <= acc + pend;
            pend <= core_exec ? bf16_to_real(w_core[core_a]) * bf16_to_real(core_d) : 0.0;
        end
        if (core_exec) begin
            a_log[exec_total[11:0]] <= core_a;
            exec_total              <= exec_total + 1;
        end
        if (norm_en) nrm <= real_to_fp32(acc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int addr, input logic [15:0] data);
        w_we   = 1'b1;
        w_addr = addr[AW-1:0];
        w_data = data;
        step();
        w_we   = 1'b0;
    endtask

    task automatic run_job(input string tag, input int n, input logic [31:0] exp_res,
                           input int exp_lat, input int exp_exec, input bit co_write);
        int          lat;
        int          nq;
        int          first_bad;
        logic [31:0] ebase;
        logic [31:0] ibase;
        ebase  = exec_total;
        ibase  = init_total;
        len_in = n[AW:0];
        start  = 1'b1;
        step();
        start  = 1'b0;
        if (co_write) w_we = 1'b0;
        lat = 1;
        while (!result_valid && lat < 1000) begin
            step();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp_res);
        nq = int'(exec_total - ebase);
        check({tag, " exec cycles"}, nq, exp_exec);
        check({tag, " init cycles"}, init_total - ibase, (n != 0) ? 1 : 0);
        first_bad = -1;
        for (int i = 0; i < nq && i < 4096; i++) begin
            logic [31:0] idx;
            idx = ebase + i;
            if (first_bad < 0 && int'(a_log[idx[11:0]]) != i) first_bad = i;
        end
        check({tag, " core_a order"}, first_bad, -1);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({tag, " idle after handshake"}, busy, 0);
    endtask

    typedef struct {
        int          len;
        logic [15:0] w;
        logic [15:0] x;
        logic [31:0] exp_res;
        int          exp_lat;
        int          exp_exec;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1,   16'h3F80, 16'h3F80, 32'h3F80_0000, 6,   1};
        vecs[1] = '{4,   16'h3F80, 16'h4000, 32'h4100_0000, 9,   4};
        vecs[2] = '{1,   16'hBF80, 16'h4000, 32'hC000_0000, 6,   1};
        vecs[3] = '{1,   16'hBF80, 16'h4000, 32'hC000_0000, 6,   1};
        vecs[4] = '{0,   16'h3F80, 16'h3F80, 32'h0000_0000, 1,   0};
        vecs[5] = '{3,   16'h4040, 16'hC000, 32'hC190_0000, 8,   3};
        vecs[6] = '{600, 16'h3F80, 16'h3F80, 32'h4400_0000, 517, 512};

        rst_n        = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_data       = '0;
        start        = 1'b0;
        len_in       = '0;
        result_ready = 1'b0;
        for (int i = 0; i < F_SIZE; i++) x_mem[i] = '0;
        repeat (3) step();
        check("reset busy", busy, 0);
        check("reset result_valid", result_valid, 0);
        check("reset result", result, 0);
        check("reset strobes", {core_exec, core_init, x_re, norm_en, core_write}, 0);
        rst_n = 1'b1;
        step();

        w_we = 1'b1; w_addr = 9'd5; w_data = 16'h1234;
        #1;
        check("idle passthrough", {core_write, 7'd0, core_a, core_d}, {1'b1, 7'd0, 9'd5, 16'h1234});
        w_we = 1'b0;
        step();

        for (int v = 0; v < 7; v++) begin
            int n;
            n = (vecs[v].len > F_SIZE) ? F_SIZE : vecs[v].len;
            for (int i = 0; i < n; i++) begin
                host_write(i, vecs[v].w);
                x_mem[i] = vecs[v].x;
            end
            run_job($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp_res,
                    vecs[v].exp_lat, vecs[v].exp_exec, 1'b0);
        end

        // Stalled consumer: output must hold and host traffic must be dropped.
        host_write(0, 16'h3F80);
        host_write(1, 16'h3F80);
        x_mem[0] = 16'h4000;
        x_mem[1] = 16'h4000;
        len_in = 10'd2;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 20 && !result_valid; i++) step();
        for (int i = 0; i < 10; i++) begin
            start = 1'b1; w_we = 1'b1; w_addr = 9'd7; w_data = 16'h4000;
            #1;
            check($sformatf("stall hold c%0d", i),
                  {result_valid, busy, core_write, 29'd0}, {1'b1, 1'b1, 1'b0, 29'd0});
            check($sformatf("stall result c%0d", i), result, 32'h4080_0000);
            step();
        end
        w_we = 1'b0;
        result_ready = 1'b1;
        step();
        start = 1'b0;
        result_ready = 1'b0;
        check("stall release idle", {busy, result_valid}, 2'b00);
        step();

        // Reset in the middle of RUN aborts the job.
        for (int i = 0; i < 8; i++) begin
            host_write(i, 16'h3F80);
            x_mem[i] = 16'h3F80;
        end
        len_in = 10'd8;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (4) step();
        check("mid-run cnt3", {core_exec, x_re, core_a, x_addr}, {1'b1, 1'b1, 9'd3, 9'd4});
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs",
              {busy, result_valid, core_exec, core_init, x_re, norm_en}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        host_write(0, 16'h4000);
        x_mem[0] = 16'h3F80;
        w_we = 1'b1; w_addr = 9'd0; w_data = 16'h3F80;
        run_job("post-reset", 1, 32'h3F80_0000, 6, 1, 1'b1);

        // Random jobs against a plain dot-product reference.
        for (int j = 0; j < 20; j++) begin
            int n;
            int sum;
            n   = int'($urandom_range(1, 24));
            sum = 0;
            for (int i = 0; i < n; i++) begin
                int wi;
                int xi;
                wi = int'($urandom_range(0, 16)) - 8;
                xi = int'($urandom_range(0, 16)) - 8;
                host_write(i, int_to_bf16(wi));
                x_mem[i] = int_to_bf16(xi);
                sum += wi * xi;
            end
            run_job($sformatf("rand%0d", j), n, real_to_fp32(real'(sum)), n + 5, n, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
